// File: rtl/seq_shifter_32.sv
// rtl/seq_shifter_32.sv - one-bit-per-cycle 32-bit barrel replacement shifter
module seq_shifter_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        arith,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] work_q;
  logic [4:0]  cnt_q;
  logic        dir_q;
  logic        arith_q;
  logic        accept;
  logic [31:0] step;

  // A request is only taken while idle; start in SHIFT/DONE is dropped.
  assign accept = (state == IDLE) && start;

  // One-bit shift of the working register using the latched controls.
  always_comb begin
    step = work_q;
    if (dir_q) begin
      step = {work_q[30:0], 1'b0};
    end else begin
      step = {(arith_q & work_q[31]), work_q[31:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length request goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (shamt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd1) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working register, counter and latched controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= 32'h0000_0000;
      cnt_q   <= 5'd0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (accept) begin
      work_q  <= a;
      cnt_q   <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (state == SHIFT) begin
      work_q <= step;
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  // Outputs decode only registered state, so no input reaches an output.
  always_comb begin
    out  = work_q;
    busy = (state == SHIFT) || (state == DONE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq_shifter_32.sv
// tb/tb_seq_shifter_32.sv - vector table plus scoreboard bench for seq_shifter_32
module tb_seq_shifter_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        dir;
  logic        arith;
  logic [31:0] out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic [31:0] exp_out;
    int          inj;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  seq_shifter_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shamt (shamt),
    .dir   (dir),
    .arith (arith),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v, input logic [4:0] s,
                                        input logic d, input logic ar);
    if (d) return v << s;
    else if (ar) return 32'($signed(v) >>> s);
    else return v >> s;
  endfunction

  // Issue one request, scramble inputs after accept, optionally poke start
  // at cycle inj after accept, and check result, latency and busy length.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [4:0] ts,
                        input logic td, input logic tar, input logic [31:0] texp,
                        input int inj);
    exp_t e;
    int   cyc;
    int   busy_cnt;
    bit   seen;
    @(negedge clk);
    a = ta; shamt = ts; dir = td; arith = tar; start = 1'b1;
    e.out = texp;
    e.lat = int'(ts) + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; shamt = ~ts; dir = ~td; arith = ~tar;
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        e = sb.pop_front();
        check({name, " out"}, out, e.out);
        check({name, " latency"}, 32'(cyc), 32'(e.lat));
      end
      if (inj == cyc) begin
        start = 1'b1; a = 32'h1234_5678; shamt = 5'd3; dir = 1'b0; arith = 1'b0;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no done within 40 cycles, expected at cycle %0d", name, int'(ts) + 1);
      sb.delete();
    end
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(int'(ts) + 1));
    @(negedge clk);
    start = 1'b0;
    check({name, " idle busy"}, {31'd0, busy}, 32'd0);
    check({name, " idle done"}, {31'd0, done}, 32'd0);
    check({name, " out hold"}, out, texp);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] ra;
    logic [4:0]  rs;
    logic        rd;
    logic        rar;

    vecs[0] = '{32'h8000_0001, 5'd0,  1'b0, 1'b1, 32'h8000_0001, 0};
    vecs[1] = '{32'hF000_0000, 5'd4,  1'b0, 1'b1, 32'hFF00_0000, 5};
    vecs[2] = '{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 0};
    vecs[3] = '{32'h0000_00FF, 5'd8,  1'b1, 1'b1, 32'h0000_FF00, 3};
    vecs[4] = '{32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 0};
    vecs[5] = '{32'h0000_F00F, 5'd4,  1'b0, 1'b0, 32'h0000_0F00, 0};
    vecs[6] = '{32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000, 0};
    vecs[7] = '{32'h7FFF_FFFF, 5'd1,  1'b0, 1'b1, 32'h3FFF_FFFF, 1};
    vecs[8] = '{32'hA5A5_A5A5, 5'd16, 1'b1, 1'b0, 32'hA5A5_0000, 0};
    vecs[9] = '{32'hA5A5_A5A5, 5'd16, 1'b0, 1'b1, 32'hFFFF_A5A5, 0};

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; shamt = '0; dir = 1'b0; arith = 1'b0;

    #12;
    check("reset out", out, 32'h0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].shamt, vecs[i].dir,
             vecs[i].arith, vecs[i].exp_out, vecs[i].inj);
    end

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      rd  = 1'($urandom_range(0, 1));
      rar = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rs, rd, rar, model(ra, rs, rd, rar), 0);
    end

    // Reset in the middle of a 20-step operation.
    @(negedge clk);
    a = 32'hDEAD_BEEF; shamt = 5'd20; dir = 1'b1; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset out", out, 32'h0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held reset done", {31'd0, done}, 32'd0);
      check("held reset busy", {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post-reset no done", {31'd0, done}, 32'd0);
    end
    run_op("after reset", 32'h0000_0002, 5'd1, 1'b0, 1'b0, 32'h0000_0001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shifter_32.md
SEQ_SHIFTER_32 -- requirements
Module: seq_shifter_32

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 The port list SHALL be as follows:
  - clk  input  1  single clock; all state updates on rising edge.
  - rst_n  input  1  reset, asynchronous and active-low.
  - start  input  1  request a new shift; sampled on clk rising edge.
  - a  input  32  operand to be shifted.
  - shamt  input  5  shift amount, 0..31.
  - dir  input  1  shift direction: 0 = right, 1 = left.
  - arith  input  1  right-shift fill: 1 = arithmetic (replicate bit 31), 0 = logical (zero fill).
  - out  output  32  shift result.
  - busy  output  1  high while an operation is in progress.
  - done  output  1  one-cycle pulse marking out as valid.

Function
REQ-003 The block SHALL implement an FSM with three states: IDLE, SHIFT, DONE.
REQ-004 On a rising edge in IDLE with start=1 (accept), the block SHALL perform the following updates:
  - load the working register with a;
  - load the counter with shamt;
  - latch dir and arith;
  - go to DONE if shamt=0, else to SHIFT.
REQ-005 On start=1 in SHIFT or DONE, the block SHALL ignore start, with no effect on state, counter, register or latched controls.
REQ-006 On each rising edge in SHIFT, the block SHALL shift the working register by exactly one bit position and decrement the counter by 1.
REQ-007 In SHIFT, the block SHALL move to DONE on the edge where the counter goes from 1 to 0.
REQ-008 For a right shift with arith=1, the one-bit step SHALL be reg[i] <= reg[i+1] for i=0..30 and reg[31] <= reg[31].
REQ-009 For a right shift with arith=0, the one-bit step SHALL be as in REQ-008 except reg[31] <= 0.
REQ-010 For a left shift, the one-bit step SHALL be reg[i] <= reg[i-1] for i=1..31 and reg[0] <= 0; arith SHALL be ignored.
REQ-011 In DONE, the block SHALL assert done=1 for exactly one cycle and then return to IDLE on the next edge.
REQ-012 done SHALL be asserted in the cycle beginning shamt+1 rising edges after the accept edge, giving a total latency of shamt+1 cycles.
REQ-013 busy SHALL equal 1 exactly when the state is SHIFT or DONE, and 0 in IDLE.
REQ-014 out SHALL be driven directly from the working register.
REQ-015 out SHALL be valid when done=1 and SHALL hold that value through IDLE until the next accept.
REQ-016 Intermediate values of out during SHIFT SHALL be treated as don't-care by consumers.
REQ-017 Because a new accept cannot occur in DONE, back-to-back operations SHALL be separated by at least one IDLE cycle.
REQ-018 Changes to a, shamt, dir or arith after the accept edge SHALL have no effect on the operation in progress.
REQ-019 The block SHALL contain no combinational path from any input to any output; all outputs are registered.

Reset
REQ-020 While rst_n=0, regardless of clk, the block SHALL immediately force the following values:
  - state = IDLE;
  - working register and out = 0x00000000;
  - counter = 0;
  - busy = 0 and done = 0.
REQ-021 When rst_n=0 is asserted mid-operation, the block SHALL abort the operation with no done pulse, and no residual state SHALL survive.
REQ-022 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-023 The bench SHALL cover a zero-length shift: a=0x80000001, shamt=0, dir=0, arith=1 -> done high in the cycle after accept, out=0x80000001, busy high for 1 cycle.
REQ-024 The bench SHALL cover an arithmetic right shift: a=0xF0000000, shamt=4, dir=0, arith=1 -> done in the 5th cycle after accept, out=0xFF000000, busy high for 5 cycles.
REQ-025 The bench SHALL cover a maximum-length logical right shift: a=0x80000000, shamt=31, dir=0, arith=0 -> done after 32 cycles, out=0x00000001.
REQ-026 The bench SHALL cover a left shift with arith ignored: a=0x000000FF, shamt=8, dir=1, arith=1 -> out=0x0000FF00 with done after 9 cycles; a second start while busy (a=0x12345678) is ignored and the result is unchanged.
REQ-027 The bench SHALL cover reset mid-operation: accept shamt=20, then drive rst_n=0 asynchronously at cycle 10 -> out=0, busy=0, done=0 immediately with no done pulse; after release, an accept with a=0x00000002, shamt=1, dir=0, arith=0 yields out=0x00000001.
